// File: rtl/sipo_rx.sv
// sipo_rx: LSB-first serial-in parallel-out receive deserializer.
// Bits arrive one per i_shift strobe; each completed N-bit word is offered
// on a one-deep holding register with a valid/ready handshake. A word that
// completes while the holding register is still occupied is dropped and
// recorded in a sticky overrun flag.
module sipo_rx #(
   parameter int   N = 8,
   parameter logic R = 1'b0
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_shift,
   input  logic                   i_data,
   input  logic                   i_clear,
   input  logic                   i_ready,
   output logic [N-1:0]           o_data,
   output logic                   o_valid,
   output logic                   o_busy,
   output logic                   o_overrun,
   output logic [$clog2(N+1)-1:0] o_count
);

   localparam int CW = $clog2(N + 1);
   localparam logic [N-1:0] FILL = {N{R}};

   // A zero-width or negative word makes no sense; stop at elaboration.
   generate
      if (N < 1) begin : g_bad_n
         $error("sipo_rx: parameter N must be at least 1");
      end
   endgenerate

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RECV = 1'b1
   } state_t;

   state_t          r_state;
   logic [N-1:0]    r_shift;
   logic [CW-1:0]   r_count;
   logic            r_busy;
   logic [N-1:0]    r_data;
   logic            r_valid;
   logic            r_overrun;

   logic [N-1:0]    w_candidate;
   logic            w_last;
   logic            w_strobe;
   logic            w_complete;
   logic            w_accept;
   logic            w_slot_free;
   logic            w_unused_lsb;

   // The word as it would look after this strobe: new bit enters at the top,
   // everything else moves one place toward bit 0.
   generate
      if (N == 1) begin : g_cand_n1
         assign w_candidate = i_data;
      end else begin : g_cand_nx
         assign w_candidate = {i_data, r_shift[N-1:1]};
      end
   endgenerate

   // Bit 0 of the shift register is shifted out on every strobe and never
   // reaches a word; it only exists so the register keeps its natural width.
   assign w_unused_lsb = r_shift[0];

   // A strobe is ignored in a clear cycle; clear wins.
   assign w_strobe    = i_shift && !i_clear;
   assign w_last      = (r_count == CW'(N - 1));
   assign w_complete  = w_strobe && w_last;
   assign w_accept    = r_valid && i_ready;
   // The slot can take a new word if empty or being emptied on this edge.
   assign w_slot_free = !r_valid || i_ready;

   // Receive FSM: bit counter, shift register and registered busy flag.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= ST_IDLE;
         r_count <= '0;
         r_shift <= FILL;
         r_busy  <= 1'b0;
      end else if (i_clear) begin
         r_state <= ST_IDLE;
         r_count <= '0;
         r_shift <= FILL;
         r_busy  <= 1'b0;
      end else if (i_shift) begin
         r_shift <= w_candidate;
         case (r_state)
            ST_IDLE: begin
               if (w_last) begin
                  // Only reachable for N == 1: every strobe is a full word.
                  r_state <= ST_IDLE;
                  r_count <= '0;
                  r_busy  <= 1'b0;
               end else begin
                  r_state <= ST_RECV;
                  r_count <= r_count + CW'(1);
                  r_busy  <= 1'b1;
               end
            end
            ST_RECV: begin
               if (w_last) begin
                  r_state <= ST_IDLE;
                  r_count <= '0;
                  r_busy  <= 1'b0;
               end else begin
                  r_state <= ST_RECV;
                  r_count <= r_count + CW'(1);
                  r_busy  <= 1'b1;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_count <= '0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   // Holding register: load on completion into a free slot, empty on accept.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_data  <= FILL;
         r_valid <= 1'b0;
      end else if (w_complete && w_slot_free) begin
         r_data  <= w_candidate;
         r_valid <= 1'b1;
      end else if (w_accept) begin
         r_valid <= 1'b0;
      end
   end

   // Sticky overrun: set by a dropped word, cleared by reset or clear.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_overrun <= 1'b0;
      end else if (i_clear) begin
         r_overrun <= 1'b0;
      end else if (w_complete && !w_slot_free) begin
         r_overrun <= 1'b1;
      end
   end

   assign o_data    = r_data;
   assign o_valid   = r_valid;
   assign o_busy    = r_busy;
   assign o_overrun = r_overrun;
   assign o_count   = r_count;

`ifdef FORMAL
   a_count_range: assert property (@(posedge i_clk) r_count < CW'(N));
   a_busy_match:  assert property (@(posedge i_clk) r_busy == (r_count != '0));
   a_valid_fall:  assert property (@(posedge i_clk) disable iff (i_rst)
                     (r_valid && !i_ready) |=> r_valid);
   a_data_stable: assert property (@(posedge i_clk) disable iff (i_rst)
                     (r_valid && !i_ready) |=> $stable(r_data));
`endif

endmodule

// File: doc/sipo_rx.md
Name: sipo_rx

Overview:
- Serial-in parallel-out receive deserializer; the receiving end of the team's LSB-first shift-register serial link.
- Collects N bits, one per i_shift strobe, and presents each completed word on a one-deep output holding register with a valid/ready handshake.
- Reports a partial frame in progress and flags overruns.
- Sits between a bit-level line interface (UART/SPI-style front ends) and a word-level consumer.

Parameters:
N, 8, word width in bits; N < 1 is an elaboration-time $error
R, 0, fill bit written into the shift and holding registers on reset and on i_clear

Ports:
i_clk  input  1  clock, all logic on rising edge
i_rst  input  1  synchronous active-high reset
i_shift  input  1  bit strobe; sample i_data this cycle
i_data  input  1  serial bit, LSB of word first
i_clear  input  1  abort partial frame, clear overrun flag
i_ready  input  1  consumer accepts o_data this cycle
o_data  output  N  received word (holding register)
o_valid  output  1  o_data holds an unconsumed word
o_busy  output  1  partial frame in progress (bit count != 0)
o_overrun  output  1  sticky: a completed word was dropped
o_count  output  $clog2(N+1)  bits collected in current frame, 0..N-1

Behaviour:
- Reset (i_rst high at edge): shift register = {N{R}}, o_data = {N{R}}, o_valid = 0, o_overrun = 0, count = 0, o_busy = 0. Reset overrides every other input, including mid-frame.
- Receive FSM has two states.
  - IDLE: count == 0.
  - RECV: 0 < count < N.
  - o_busy = (state == RECV), a registered state, not a combinational decode of inputs.
- On an i_shift edge:
  - Shift register <= {i_data, shift[N-1:1]}, so the first bit ends in bit 0 after N strobes.
  - count increments.
- Frame completion: an i_shift edge with count == N-1.
  - The assembled word {i_data, shift[N-1:1]} is the candidate.
  - count -> 0 and the FSM returns to IDLE in the same edge.
  - For N = 1, every strobe completes a frame.
- i_shift low: shift register and count hold. Strobes need not be contiguous; gaps of any length are allowed.
- Holding register:
  - Completion with the slot free, or freed this edge (o_valid == 0, or o_valid && i_ready): o_data <= candidate, o_valid <= 1.
  - Accept (o_valid && i_ready) without completion: o_valid <= 0, o_data holds its value.
  - Completion while o_valid && !i_ready: candidate dropped, o_data and o_valid unchanged, o_overrun <= 1.
- Latency: o_valid rises on the edge that samples the N-th strobe, visible the cycle after.
- Back-to-back: with i_ready held high, each completed word is presented with no bubble beyond strobe spacing.
- i_clear (priority over i_shift in the same cycle):
  - count -> 0, shift register -> {N{R}}, FSM -> IDLE, o_overrun -> 0.
  - The bit on i_data that cycle is discarded.
  - o_data and o_valid are untouched; the i_ready handshake still completes in a clear cycle.
- o_overrun: set only by a dropped word; cleared only by i_rst or i_clear.
- Counter width: $clog2(N+1) bits. The counter never exceeds N-1, with no wrap beyond it.
- Formal (under FORMAL):
  - count < N always.
  - o_busy == (count != 0).
  - o_valid falls only after o_valid && i_ready.
  - $stable(o_data) while o_valid && !i_ready.

Test Plan:
- N=8, strobe bits 1,0,1,0,0,1,0,1 on 8 consecutive cycles, i_ready=0 -> o_data=0xA5, o_valid=1 the cycle after the 8th strobe, o_busy=1 during strobes 1-7 then 0.
- N=8, bits of 0x3C strobed every 3rd cycle, then i_ready=1 for 1 cycle -> o_data=0x3C, o_valid drops the next cycle, o_data still 0x3C.
- i_ready held 1, words 0x01, 0xFF, 0x80 streamed on 24 consecutive strobes -> three o_valid pulses with the correct words, o_overrun=0.
- Word 0x11 received and held (i_ready=0), then 0x22 received -> o_data stays 0x11, o_overrun=1. Then i_clear -> o_overrun=0, o_valid=1, o_data=0x11.
- 4 bits strobed, then i_clear together with i_shift, then 0x5A sent in full -> o_count=0 after the clear, o_data=0x5A.
- i_rst asserted after 5 bits with o_valid=1 -> next cycle o_valid=0, o_count=0, o_data=0x00 (R=0). Repeat with R=1 and N=1: each strobe of bit 0 gives o_data=0, o_valid=1.
